// File: rtl/lw_sha_core_arbiter_if.sv
// Requester-side and core-side native signal bundle for lw_sha_core_arbiter.
// The arbiter connects through the slave modport; requesters plus core use master.
interface lw_sha_core_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int WORD_SIZE = 64
);
    logic [NUM_REQ-1:0]           req_start_i;
    logic [4*NUM_REQ-1:0]         req_opcode_i;
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_last_i;
    logic [WORD_SIZE*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]           req_abort_i;
    logic [NUM_REQ-1:0]           req_grant_o;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ-1:0]           req_done_o;
    logic [NUM_REQ-1:0]           req_err_o;
    logic                         core_start_o;
    logic [3:0]                   core_opcode_o;
    logic                         core_valid_o;
    logic [WORD_SIZE-1:0]         core_data_o;
    logic                         core_last_o;
    logic                         core_abort_o;
    logic                         core_ready_i;
    logic                         core_idle_i;
    logic                         core_done_i;
    logic                         fault_inj_det_i;
    logic                         fault_o;

    modport slave (
        input  req_start_i, req_opcode_i, req_valid_i, req_last_i, req_data_i, req_abort_i,
        input  core_ready_i, core_idle_i, core_done_i, fault_inj_det_i,
        output req_grant_o, req_ready_o, req_done_o, req_err_o,
        output core_start_o, core_opcode_o, core_valid_o, core_data_o, core_last_o, core_abort_o,
        output fault_o
    );

    modport master (
        output req_start_i, req_opcode_i, req_valid_i, req_last_i, req_data_i, req_abort_i,
        output core_ready_i, core_idle_i, core_done_i, fault_inj_det_i,
        input  req_grant_o, req_ready_o, req_done_o, req_err_o,
        input  core_start_o, core_opcode_o, core_valid_o, core_data_o, core_last_o, core_abort_o,
        input  fault_o
    );
endinterface

// File: rtl/lw_sha_core_arbiter.sv
// Round-robin per-message arbiter sharing one SHA core between NUM_REQ requesters.
// Optional stall watchdog enabled by defining SHA_ARB_TIMEOUT_EN.
module lw_sha_core_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int WORD_SIZE      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    lw_sha_core_arbiter_if.slave sha_bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_STREAM     = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_ABORT      = 3'd4,
        S_ABORT_WAIT = 3'd5
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("lw_sha_core_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    // First requester at or after ptr, wrapping; MSB flags that one was found.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] reqs, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            res = reqs[idx] ? {1'b1, IW'(idx)} : res;
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + IW'(1);
    endfunction

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_owner, w_owner_nxt;
    logic [IW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_err, w_err_nxt;
    logic [3:0]           r_opcode, w_opcode_nxt;
    logic                 r_core_start, w_core_start_nxt;
    logic                 r_core_last, w_core_last_nxt;
    logic                 r_core_abort, w_core_abort_nxt;
    logic                 r_fault, r_fault_d;

    logic [IW:0]          w_pick;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic                 w_streaming;
    logic                 w_own_valid, w_own_last, w_own_abort;
    logic [WORD_SIZE-1:0] w_own_data;
    logic                 w_core_valid;
    logic                 w_beat;
    logic                 w_fault_rise;
    logic                 w_timeout;

    assign w_pick        = rr_pick(sha_bus.req_start_i, r_rr_ptr);
    assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick[IW-1:0];
    assign w_streaming   = (r_state == S_STREAM);
    assign w_own_valid   = sha_bus.req_valid_i[r_owner];
    assign w_own_last    = sha_bus.req_last_i[r_owner];
    assign w_own_abort   = sha_bus.req_abort_i[r_owner];
    assign w_own_data    = sha_bus.req_data_i[int'(r_owner)*WORD_SIZE +: WORD_SIZE];
    // An abort in the same cycle as a word suppresses that word.
    assign w_core_valid  = w_streaming & w_own_valid & ~w_own_abort;
    assign w_beat        = w_core_valid & sha_bus.core_ready_i;
    assign w_fault_rise  = sha_bus.fault_inj_det_i & ~r_fault_d;

`ifdef SHA_ARB_TIMEOUT_EN
    logic [15:0] r_stall;
    logic        w_stall_run;

    assign w_stall_run = (r_state == S_STREAM) || (r_state == S_WAIT_DONE);
    assign w_timeout   = w_stall_run && (r_stall == 16'(TIMEOUT_CYCLES - 1));

    // Stall counter: restarts on every beat, on core done and whenever the state changes
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_stall <= 16'd0;
        end else if (!w_stall_run || (w_state_nxt != r_state) || w_beat || sha_bus.core_done_i) begin
            r_stall <= 16'd0;
        end else begin
            r_stall <= r_stall + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state, ownership and pulse generation
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_grant_nxt      = r_grant;
        w_opcode_nxt     = r_opcode;
        w_core_start_nxt = 1'b0;
        w_core_last_nxt  = 1'b0;
        w_core_abort_nxt = 1'b0;
        w_done_nxt       = '0;
        w_err_nxt        = '0;
        case (r_state)
            S_IDLE: begin
                if (sha_bus.core_idle_i && w_pick[IW] && !r_fault && !sha_bus.fault_inj_det_i) begin
                    w_state_nxt      = S_START;
                    w_owner_nxt      = w_pick[IW-1:0];
                    w_grant_nxt      = w_pick_onehot;
                    w_opcode_nxt     = sha_bus.req_opcode_i[int'(w_pick[IW-1:0])*4 +: 4];
                    w_core_start_nxt = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_START: begin
                if (w_own_abort || w_fault_rise) begin
                    w_state_nxt      = S_ABORT;
                    w_core_abort_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_own_abort || w_fault_rise || w_timeout) begin
                    w_state_nxt      = S_ABORT;
                    w_core_abort_nxt = 1'b1;
                end else if (w_beat && w_own_last) begin
                    w_state_nxt     = S_WAIT_DONE;
                    w_core_last_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_WAIT_DONE: begin
                // A completed hash is delivered even if an abort arrives alongside it.
                if (sha_bus.core_done_i) begin
                    w_state_nxt  = S_IDLE;
                    w_done_nxt   = r_grant;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = rr_next(r_owner);
                end else if (w_own_abort || w_fault_rise || w_timeout) begin
                    w_state_nxt      = S_ABORT;
                    w_core_abort_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_ABORT: begin
                w_state_nxt = S_ABORT_WAIT;
            end
            S_ABORT_WAIT: begin
                if (sha_bus.core_idle_i) begin
                    w_state_nxt  = S_IDLE;
                    w_err_nxt    = r_grant;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = rr_next(r_owner);
                end else begin
                    w_state_nxt = S_ABORT_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, ownership and registered pulse outputs
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_opcode     <= 4'd0;
            r_core_start <= 1'b0;
            r_core_last  <= 1'b0;
            r_core_abort <= 1'b0;
            r_done       <= '0;
            r_err        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_grant      <= w_grant_nxt;
            r_opcode     <= w_opcode_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_last  <= w_core_last_nxt;
            r_core_abort <= w_core_abort_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Sticky fault flag plus previous-cycle sample for edge detection
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_fault   <= 1'b0;
            r_fault_d <= 1'b0;
        end else begin
            r_fault   <= r_fault | sha_bus.fault_inj_det_i;
            r_fault_d <= sha_bus.fault_inj_det_i;
        end
    end

    assign sha_bus.req_grant_o   = r_grant;
    assign sha_bus.req_ready_o   = (w_streaming && sha_bus.core_ready_i) ? r_grant : '0;
    assign sha_bus.req_done_o    = r_done;
    assign sha_bus.req_err_o     = r_err;
    assign sha_bus.core_start_o  = r_core_start;
    assign sha_bus.core_opcode_o = r_opcode;
    assign sha_bus.core_valid_o  = w_core_valid;
    assign sha_bus.core_data_o   = w_streaming ? w_own_data : '0;
    assign sha_bus.core_last_o   = r_core_last;
    assign sha_bus.core_abort_o  = r_core_abort;
    assign sha_bus.fault_o       = r_fault;
endmodule

// File: tb/tb_lw_sha_core_arbiter.sv
// Self-checking bench for lw_sha_core_arbiter: directed scenarios with random data,
// stalls and request masks checked against a round-robin reference model.
module tb_lw_sha_core_arbiter;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    int   m_ptr;
    logic [3:0] opc [2];

    lw_sha_core_arbiter_if #(.NUM_REQ(2), .WORD_SIZE(64)) bus ();

    lw_sha_core_arbiter #(
        .NUM_REQ(2),
        .WORD_SIZE(64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .resetn_i(resetn),
        .sha_bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int r);
        logic [1:0] one;
        one = 2'b01;
        return one << r;
    endfunction

    // Reference rule: first requester at or after the pointer, wrapping.
    function automatic int ref_pick(input logic [1:0] mask, input int ptr);
        for (int k = 0; k < 2; k++) begin
            if (mask[(ptr + k) % 2]) return (ptr + k) % 2;
        end
        return 0;
    endfunction

    task automatic set_opc();
        opc[0] = 4'($urandom);
        opc[1] = 4'($urandom);
        bus.req_opcode_i = {opc[1], opc[0]};
    endtask

    task automatic get_grant(input int r, input bit drop_req);
        int lat;
        logic [3:0] eo;
        lat = 0;
        eo  = opc[r];
        do begin
            step();
            lat++;
            check("pulses_quiet", 64'({bus.req_done_o, bus.req_err_o}), 64'd0);
        end while (bus.req_grant_o == 2'b00 && lat < 20);
        check("grant_latency", 64'(lat), 64'd1);
        check("grant", 64'(bus.req_grant_o), 64'(onehot(r)));
        check("core_start", 64'(bus.core_start_o), 64'd1);
        check("opcode", 64'(bus.core_opcode_o), 64'(eo));
        if (drop_req) bus.req_start_i[r] = 1'b0;
        set_opc();
        step();
        check("start_pulse_width", 64'(bus.core_start_o), 64'd0);
        check("opcode_latched", 64'(bus.core_opcode_o), 64'(eo));
        check("grant_hold", 64'(bus.req_grant_o), 64'(onehot(r)));
    endtask

    task automatic stream(input int r, input int n, input bit use_last);
        int sent;
        int stall;
        int o;
        logic [63:0] word;
        bit v;
        bit rd;
        o = 1 - r;
        sent = 0;
        stall = 0;
        for (int c = 0; c < 200 && sent < n; c++) begin
            word = {$urandom, $urandom};
            v  = (stall >= 3) || ($urandom_range(0, 3) != 0);
            rd = (stall >= 3) || ($urandom_range(0, 3) != 0);
            bus.req_valid_i[r] = v;
            bus.req_last_i[r]  = use_last && (sent == n - 1);
            bus.req_data_i[r*64 +: 64] = word;
            bus.req_valid_i[o] = 1'b1;
            bus.req_last_i[o]  = 1'($urandom);
            bus.req_abort_i[o] = 1'($urandom);
            bus.req_data_i[o*64 +: 64] = ~word;
            bus.core_ready_i = rd;
            #2;
            check("core_valid", 64'(bus.core_valid_o), 64'(v));
            check("core_data", bus.core_data_o, word);
            check("req_ready", 64'(bus.req_ready_o), rd ? 64'(onehot(r)) : 64'd0);
            check("no_abort_in_stream", 64'(bus.core_abort_o), 64'd0);
            step();
            if (v && rd) begin
                sent++;
                stall = 0;
            end else begin
                stall++;
            end
            check("core_last", 64'(bus.core_last_o), 64'(use_last && v && rd && sent == n));
        end
        check("stream_beats", 64'(sent), 64'(n));
        bus.req_valid_i = 2'b00;
        bus.req_last_i  = 2'b00;
        bus.req_abort_i = 2'b00;
        bus.core_ready_i = 1'b1;
    endtask

    task automatic finish_done(input int r, input int dly, input bit with_abort);
        bus.req_valid_i[r] = 1'b1;
        for (int c = 0; c < dly; c++) begin
            step();
            check("wait_grant", 64'(bus.req_grant_o), 64'(onehot(r)));
            check("wait_no_done", 64'(bus.req_done_o), 64'd0);
            check("wait_valid_blocked", 64'(bus.core_valid_o), 64'd0);
        end
        bus.core_done_i = 1'b1;
        bus.req_abort_i[r] = with_abort;
        step();
        bus.core_done_i = 1'b0;
        bus.req_abort_i = 2'b00;
        bus.req_valid_i = 2'b00;
        check("done", 64'(bus.req_done_o), 64'(onehot(r)));
        check("grant_drop", 64'(bus.req_grant_o), 64'd0);
        check("done_beats_abort", 64'({bus.core_abort_o, bus.req_err_o}), 64'd0);
        m_ptr = (r + 1) % 2;
    endtask

    task automatic check_reset_outputs();
        check("rst_outputs", 64'({bus.req_grant_o, bus.req_ready_o, bus.req_done_o, bus.req_err_o,
                                  bus.core_start_o, bus.core_last_o, bus.core_abort_o, bus.core_valid_o,
                                  bus.core_opcode_o, bus.fault_o}), 64'd0);
        check("rst_data", bus.core_data_o, 64'd0);
    endtask

    initial begin
        int r;
        int lat;
        logic [1:0] mask;
        errors = 0;
        checks = 0;
        m_ptr  = 0;
        resetn = 1'b0;
        bus.req_start_i = 2'b00;
        bus.req_valid_i = 2'b00;
        bus.req_last_i  = 2'b00;
        bus.req_abort_i = 2'b00;
        bus.req_data_i  = '0;
        bus.core_ready_i = 1'b1;
        bus.core_idle_i  = 1'b1;
        bus.core_done_i  = 1'b0;
        bus.fault_inj_det_i = 1'b0;
        set_opc();
        repeat (3) step();
        check_reset_outputs();
        resetn = 1'b1;

        // Single requester, three beats, done five cycles later
        bus.req_start_i = 2'b01;
        r = ref_pick(2'b01, m_ptr);
        get_grant(r, 1'b1);
        stream(r, 3, 1'b1);
        finish_done(r, 5, 1'b0);

        // Both requesting: served back to back in round-robin order
        bus.req_start_i = 2'b11;
        r = ref_pick(2'b11, m_ptr);
        get_grant(r, 1'b0);
        stream(r, 2, 1'b1);
        finish_done(r, 1, 1'b0);
        r = ref_pick(2'b11, m_ptr);
        get_grant(r, 1'b0);
        stream(r, 4, 1'b1);
        finish_done(r, 0, 1'b1);

        // Random masks, lengths and done delays
        for (int m = 0; m < 10; m++) begin
            mask = 2'($urandom_range(1, 3));
            bus.req_start_i = mask;
            r = ref_pick(mask, m_ptr);
            get_grant(r, 1'($urandom));
            stream(r, $urandom_range(1, 6), 1'b1);
            finish_done(r, $urandom_range(0, 4), 1'($urandom));
        end

        // Owner abort mid-stream, coinciding with its last word
        bus.req_start_i = 2'b01;
        get_grant(0, 1'b1);
        stream(0, 2, 1'b0);
        bus.req_valid_i[0] = 1'b1;
        bus.req_last_i[0]  = 1'b1;
        bus.req_abort_i[0] = 1'b1;
        bus.core_idle_i    = 1'b0;
        #2;
        check("abort_masks_valid", 64'(bus.core_valid_o), 64'd0);
        step();
        bus.req_valid_i = 2'b00;
        bus.req_last_i  = 2'b00;
        bus.req_abort_i = 2'b00;
        check("abort_pulse", 64'(bus.core_abort_o), 64'd1);
        check("abort_no_last", 64'(bus.core_last_o), 64'd0);
        step();
        check("abort_pulse_width", 64'(bus.core_abort_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("err_waits_idle", 64'(bus.req_err_o), 64'd0);
        end
        bus.core_idle_i = 1'b1;
        step();
        check("err_pulse", 64'(bus.req_err_o), 64'(onehot(0)));
        check("err_grant_drop", 64'(bus.req_grant_o), 64'd0);
        m_ptr = 1;
        bus.req_start_i = 2'b11;
        r = ref_pick(2'b11, m_ptr);
        get_grant(r, 1'b0);
        stream(r, 1, 1'b1);
        finish_done(r, 2, 1'b0);

        // Fault while waiting for done: abort, error, sticky flag, no more grants
        bus.req_start_i = 2'b01;
        r = ref_pick(2'b01, m_ptr);
        get_grant(r, 1'b0);
        stream(r, 2, 1'b1);
        bus.fault_inj_det_i = 1'b1;
        step();
        bus.fault_inj_det_i = 1'b0;
        check("fault_abort", 64'(bus.core_abort_o), 64'd1);
        check("fault_flag", 64'(bus.fault_o), 64'd1);
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.req_err_o == 2'b00 && lat < 10);
        check("fault_err", 64'(bus.req_err_o), 64'(onehot(r)));
        bus.req_start_i = 2'b11;
        for (int c = 0; c < 20; c++) begin
            step();
            check("fault_no_grant", 64'({bus.req_grant_o, bus.core_start_o}), 64'd0);
            check("fault_sticky", 64'(bus.fault_o), 64'd1);
        end
        resetn = 1'b0;
        #2;
        check_reset_outputs();
        step();
        resetn = 1'b1;
        m_ptr = 0;
        r = ref_pick(2'b11, m_ptr);
        get_grant(r, 1'b0);
        stream(r, 2, 1'b1);
        finish_done(r, 1, 1'b0);

        // Owner stalls in STREAM
        bus.req_start_i = 2'b10;
        get_grant(1, 1'b1);
`ifdef SHA_ARB_TIMEOUT_EN
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.core_abort_o == 1'b0 && lat < 20);
        check("timeout_latency", 64'(lat), 64'd8);
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.req_err_o == 2'b00 && lat < 10);
        check("timeout_err", 64'(bus.req_err_o), 64'(onehot(1)));
        m_ptr = 0;
`else
        for (int c = 0; c < 100; c++) begin
            step();
            check("no_timeout", 64'({bus.core_abort_o, bus.req_err_o}), 64'd0);
        end
        check("stall_grant_hold", 64'(bus.req_grant_o), 64'(onehot(1)));
        stream(1, 1, 1'b1);
        finish_done(1, 2, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
